// File: rtl/branch_target_buffer_pkg.sv
// Shared constants for the branch target buffer: RV32 control-flow opcodes
// and the 2-bit saturating counter encodings.
package branch_target_buffer_pkg;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

    localparam int IDX_BITS_DEF = 5;
endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// Combinational next-value for a 2-bit saturating counter.
module branch_target_buffer_sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] nxt
);
    // Step up or down, holding at the rails instead of wrapping.
    always_comb begin
        nxt = cur;
        if (inc && !dec && cur != CNT_ST)
            nxt = cur + 2'd1;
        else if (dec && !inc && cur != CNT_SNT)
            nxt = cur - 2'd1;
    end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer. Combinational lookup for IF,
// single registered update port driven by EX-stage resolution.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int         IDX_BITS = IDX_BITS_DEF,
    parameter int         TAG_BITS = 30 - IDX_BITS,
    parameter logic [1:0] CNT_INIT = CNT_WNT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_pc,
    output logic [31:0] pc_BTB,
    output logic        pred_hit,
    output logic        pred_taken,
    input  logic        ID_EX_valid,
    input  logic [6:0]  ID_EX_opcode,
    input  logic [31:0] ID_EX_pc,
    input  logic        resolved_taken,
    input  logic [31:0] resolved_target
);
    localparam int ENTRIES = 1 << IDX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          cnt_q    [ENTRIES];

    // Word-aligned PCs: the two low bits never take part in index or tag.
    logic [3:0] unused_pc_bits;
    assign unused_pc_bits = {IF_pc[1:0], ID_EX_pc[1:0]};

    // ---------------- lookup ----------------
    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;

    assign lk_idx = IF_pc[IDX_BITS+1:2];
    assign lk_tag = IF_pc[31:IDX_BITS+2];

    // Pure function of current table state and IF_pc; updates land after the edge.
    always_comb begin
        pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken = pred_hit && cnt_q[lk_idx][1];
        pc_BTB     = pred_taken ? target_q[lk_idx] : IF_pc + 32'd4;
    end

    // ---------------- update ----------------
    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0] up_tag;
    logic                is_branch, is_jump, upd_en, taken_eff, up_hit;
    logic [1:0]          cnt_nxt;

    assign up_idx = ID_EX_pc[IDX_BITS+1:2];
    assign up_tag = ID_EX_pc[31:IDX_BITS+2];

    // Classify the EX instruction and check the indexed entry for a tag hit.
    always_comb begin
        is_branch = (ID_EX_opcode == BRANCH);
        is_jump   = (ID_EX_opcode == JAL) || (ID_EX_opcode == JALR);
        upd_en    = ID_EX_valid && (is_branch || is_jump);
        taken_eff = is_jump || resolved_taken;
        up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    branch_target_buffer_sat_counter2 u_cnt (
        .cur (cnt_q[up_idx]),
        .inc (taken_eff),
        .dec (!taken_eff),
        .nxt (cnt_nxt)
    );

    // Table write: reset clears everything and drops any concurrent update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                if (is_jump) begin
                    // JALR may move every time, so always refresh the target.
                    cnt_q[up_idx]    <= CNT_ST;
                    target_q[up_idx] <= resolved_target;
                end else begin
                    cnt_q[up_idx] <= cnt_nxt;
                    if (taken_eff)
                        target_q[up_idx] <= resolved_target;
                end
            end else if (taken_eff) begin
                // Allocate on taken only; a not-taken miss leaves any alias alone.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= resolved_target;
                cnt_q[up_idx]    <= is_jump ? CNT_ST : CNT_WT;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: a table of per-cycle vectors, each carrying
// the expected lookup for that cycle, pushed to a scoreboard when driven and
// compared on the falling edge.
module tb_branch_target_buffer;
    localparam logic [6:0] OB = 7'b1100011;  // BRANCH
    localparam logic [6:0] OJ = 7'b1101111;  // JAL
    localparam logic [6:0] OR = 7'b1100111;  // JALR
    localparam logic [6:0] OA = 7'b0110011;  // ALU op, not control flow

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_pc;
    logic [31:0] pc_BTB;
    logic        pred_hit;
    logic        pred_taken;
    logic        ID_EX_valid;
    logic [6:0]  ID_EX_opcode;
    logic [31:0] ID_EX_pc;
    logic        resolved_taken;
    logic [31:0] resolved_target;

    branch_target_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .IF_pc           (IF_pc),
        .pc_BTB          (pc_BTB),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .ID_EX_valid     (ID_EX_valid),
        .ID_EX_opcode    (ID_EX_opcode),
        .ID_EX_pc        (ID_EX_pc),
        .resolved_taken  (resolved_taken),
        .resolved_target (resolved_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        uv;
        logic [6:0]  op;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] lpc;
        logic        e_hit;
        logic        e_tkn;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        string       name;
        logic        hit;
        logic        tkn;
        logic [31:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(string name, logic rst, logic uv, logic [6:0] op,
                                logic [31:0] upc, logic tk, logic [31:0] tgt,
                                logic [31:0] lpc, logic e_hit, logic e_tkn,
                                logic [31:0] e_pc);
        vec_t v;
        v.name = name; v.rst = rst; v.uv = uv; v.op = op; v.upc = upc; v.tk = tk;
        v.tgt = tgt; v.lpc = lpc; v.e_hit = e_hit; v.e_tkn = e_tkn; v.e_pc = e_pc;
        return v;
    endfunction

    // Drive one cycle of stimulus, push its expectation, check at negedge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        reset           = v.rst;
        ID_EX_valid     = v.uv;
        ID_EX_opcode    = v.op;
        ID_EX_pc        = v.upc;
        resolved_taken  = v.tk;
        resolved_target = v.tgt;
        IF_pc           = v.lpc;
        sb.push_back('{v.name, v.e_hit, v.e_tkn, v.e_pc});
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (pred_hit !== e.hit) begin
            bad++;
            $display("FAIL %s pred_hit got=%b want=%b", e.name, pred_hit, e.hit);
        end
        total++;
        if (pred_taken !== e.tkn) begin
            bad++;
            $display("FAIL %s pred_taken got=%b want=%b", e.name, pred_taken, e.tkn);
        end
        total++;
        if (pc_BTB !== e.pc) begin
            bad++;
            $display("FAIL %s pc_BTB got=%h want=%h", e.name, pc_BTB, e.pc);
        end
    endtask

    initial begin
        reset = 1'b1; ID_EX_valid = 1'b0; ID_EX_opcode = OA; ID_EX_pc = '0;
        resolved_taken = 1'b0; resolved_target = '0; IF_pc = '0;
        repeat (2) @(posedge clk);

        // name            rst uv op  upc     tk tgt     lpc         hit tk  pc
        vecs.push_back(mk("t1_rst_upd",   1, 1, OB, 32'h40, 1, 32'h80,  32'h40, 0, 0, 32'h44));
        vecs.push_back(mk("t1_dropped",   0, 0, OA, 32'h0,  0, 32'h0,   32'h40, 0, 0, 32'h44));
        vecs.push_back(mk("t6_same_cyc",  0, 1, OB, 32'h40, 1, 32'h80,  32'h40, 0, 0, 32'h44));
        vecs.push_back(mk("t2_alloc_wt",  0, 0, OA, 32'h0,  0, 32'h0,   32'h40, 1, 1, 32'h80));
        vecs.push_back(mk("t3_nt_1",      0, 1, OB, 32'h40, 0, 32'h990, 32'h40, 1, 1, 32'h80));
        vecs.push_back(mk("t3_cnt01",     0, 1, OB, 32'h40, 0, 32'h990, 32'h40, 1, 0, 32'h44));
        vecs.push_back(mk("t3_cnt00",     0, 1, OB, 32'h40, 0, 32'h990, 32'h40, 1, 0, 32'h44));
        vecs.push_back(mk("t3_sat00",     0, 1, OB, 32'h40, 1, 32'h80,  32'h40, 1, 0, 32'h44));
        vecs.push_back(mk("t3_cnt01b",    0, 1, OB, 32'h40, 1, 32'h80,  32'h40, 1, 0, 32'h44));
        vecs.push_back(mk("t3_cnt10",     0, 1, OB, 32'h40, 1, 32'h80,  32'h40, 1, 1, 32'h80));
        vecs.push_back(mk("t3_cnt11",     0, 1, OB, 32'h40, 1, 32'h80,  32'h40, 1, 1, 32'h80));
        vecs.push_back(mk("t3_sat11",     0, 1, OB, 32'h40, 0, 32'h990, 32'h40, 1, 1, 32'h80));
        vecs.push_back(mk("t3_nt_keeptg", 0, 0, OA, 32'h0,  0, 32'h0,   32'h40, 1, 1, 32'h80));
        vecs.push_back(mk("t4_alias_nt",  0, 1, OB, 32'hC0, 0, 32'h500, 32'hC0, 0, 0, 32'hC4));
        vecs.push_back(mk("t4_victim_ok", 0, 0, OA, 32'h0,  0, 32'h0,   32'h40, 1, 1, 32'h80));
        vecs.push_back(mk("t4_jal_evict", 0, 1, OJ, 32'hC0, 0, 32'h200, 32'hC0, 0, 0, 32'hC4));
        vecs.push_back(mk("t4_jal_hit",   0, 0, OA, 32'h0,  0, 32'h0,   32'hC0, 1, 1, 32'h200));
        vecs.push_back(mk("t4_evicted",   0, 0, OA, 32'h0,  0, 32'h0,   32'h40, 0, 0, 32'h44));
        vecs.push_back(mk("t5_jalr_1",    0, 1, OR, 32'h100,0, 32'h300, 32'h100,0, 0, 32'h104));
        vecs.push_back(mk("t5_jalr_2",    0, 1, OR, 32'h100,0, 32'h340, 32'h100,1, 1, 32'h300));
        vecs.push_back(mk("t5_inval_upd", 0, 0, OR, 32'h100,1, 32'h380, 32'h100,1, 1, 32'h340));
        vecs.push_back(mk("t5_alu_upd",   0, 1, OA, 32'h100,1, 32'h3C0, 32'h100,1, 1, 32'h340));
        vecs.push_back(mk("t5_nochange",  0, 0, OA, 32'h0,  0, 32'h0,   32'h100,1, 1, 32'h340));
        vecs.push_back(mk("wrap_pc4",     0, 0, OA, 32'h0,  0, 32'h0,   32'hFFFFFFFC, 0, 0, 32'h0));

        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-run, held two cycles: every learned entry must be gone.
        apply(mk("rst_hold_a", 1, 0, OA, 32'h0, 0, 32'h0, 32'hC0, 1, 1, 32'h200));
        apply(mk("rst_hold_b", 1, 1, OJ, 32'h100, 1, 32'h999, 32'hC0, 0, 0, 32'hC4));
        apply(mk("rst_clr_jal", 0, 0, OA, 32'h0, 0, 32'h0, 32'hC0, 0, 0, 32'hC4));
        apply(mk("rst_clr_jalr",0, 0, OA, 32'h0, 0, 32'h0, 32'h100, 0, 0, 32'h104));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
